// File: rtl/param_register_file_if.sv
// param_register_file_if: read, write, link and PC signals of the register file
interface param_register_file_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 4
);
  logic [ADDR_W-1:0] sa, sb, sd, c;
  logic [DATA_W-1:0] pa, pb, pd, pw, lrin, pcin, pcout, r14out;
  logic rfld, lrld, hzpcld;
  modport master (
    output sa, sb, sd, c, pw, rfld, lrin, lrld, pcin, hzpcld,
    input  pa, pb, pd, pcout, r14out
  );
  modport slave (
    input  sa, sb, sd, c, pw, rfld, lrin, lrld, pcin, hzpcld,
    output pa, pb, pd, pcout, r14out
  );
endinterface

// File: rtl/param_register_file.sv
// param_register_file: register file with three read ports, link and PC write paths, optional forwarding
module param_register_file #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 4,
  parameter int LR_IDX = 14,
  parameter int BYPASS = 1
) (
  input logic clk,
  input logic rst,
  param_register_file_if.slave bus
);
  localparam int NUM_REGS = 2 ** ADDR_W;
  localparam int PCI = NUM_REGS - 1;
  localparam logic [ADDR_W-1:0] LR_SEL = ADDR_W'(LR_IDX);
  logic [DATA_W-1:0] regs [NUM_REGS];
  logic [DATA_W-1:0] nxt [NUM_REGS];
  logic [NUM_REGS-1:0] wen;
  logic [ADDR_W-1:0] sel [3];
  logic [DATA_W-1:0] dat [3];
  // gating by rfld first keeps an unknown c from reaching the decode
  assign wen = bus.rfld ? (NUM_REGS'(1) << bus.c) : '0;
  always_comb begin
    for (int i = 0; i < NUM_REGS; i++)
      nxt[i] = wen[i] ? bus.pw :
               (i == LR_IDX && bus.lrld) ? bus.lrin :
               (i == PCI && bus.hzpcld) ? bus.pcin : regs[i];
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      for (int i = 0; i < NUM_REGS; i++) regs[i] <= '0;
    else
      regs <= nxt;
  end
  assign sel[0] = bus.sa;
  assign sel[1] = bus.sb;
  assign sel[2] = bus.sd;
  // pcin is never forwarded; the PC is only bypassed through the main write port
  for (genvar p = 0; p < 3; p++) begin : g_rd
    assign dat[p] = rst ? '0 :
                    (BYPASS != 0 && bus.rfld && sel[p] == bus.c) ? bus.pw :
                    (BYPASS != 0 && bus.lrld && sel[p] == LR_SEL) ? bus.lrin :
                    regs[sel[p]];
  end
  assign bus.pa = dat[0];
  assign bus.pb = dat[1];
  assign bus.pd = dat[2];
  assign bus.pcout = regs[PCI];
  assign bus.r14out = regs[LR_IDX];
endmodule

// File: tb/tb_param_register_file.sv
// tb_param_register_file: scoreboard bench comparing forwarding and non-forwarding instances to a register model
module tb_param_register_file;
  logic clk = 0;
  logic rst = 1;
  always #5 clk = ~clk;
  param_register_file_if #(.DATA_W(32), .ADDR_W(4)) bf ();
  param_register_file_if #(.DATA_W(32), .ADDR_W(4)) bn ();
  param_register_file #(.DATA_W(32), .ADDR_W(4), .LR_IDX(14), .BYPASS(1)) dut_f (.clk(clk), .rst(rst), .bus(bf));
  param_register_file #(.DATA_W(32), .ADDR_W(4), .LR_IDX(14), .BYPASS(0)) dut_n (.clk(clk), .rst(rst), .bus(bn));
  typedef struct {
    logic [3:0] sa, sb, sd, c;
    logic [31:0] pw, lrin, pcin;
    logic rfld, lrld, hz;
    int rm;
  } stim_t;
  typedef struct {
    logic [9:0][31:0] v;
  } exp_t;
  exp_t q[$];
  logic [31:0] m [16];
  int n_cmp = 0;
  int n_bad = 0;
  string names [10] = '{"f_pa", "f_pb", "f_pd", "f_pc", "f_r14", "n_pa", "n_pb", "n_pd", "n_pc", "n_r14"};
  function automatic logic [31:0] rd(input stim_t s, input logic [3:0] a, input bit byp);
    if (byp && s.rfld && a == s.c) return s.pw;
    if (byp && s.lrld && a == 4'd14) return s.lrin;
    return m[a];
  endfunction
  task automatic drive(input stim_t s);
    bf.sa = s.sa; bf.sb = s.sb; bf.sd = s.sd; bf.c = s.c; bf.pw = s.pw;
    bf.rfld = s.rfld; bf.lrin = s.lrin; bf.lrld = s.lrld; bf.pcin = s.pcin; bf.hzpcld = s.hz;
    bn.sa = s.sa; bn.sb = s.sb; bn.sd = s.sd; bn.c = s.c; bn.pw = s.pw;
    bn.rfld = s.rfld; bn.lrin = s.lrin; bn.lrld = s.lrld; bn.pcin = s.pcin; bn.hzpcld = s.hz;
  endtask
  // rm: 0 no reset, 1 reset pulse between edges, 2 reset held across the edge
  task automatic cycle(input stim_t s);
    exp_t e;
    @(negedge clk);
    drive(s);
    if (s.rm != 0) begin
      rst = 1;
      for (int i = 0; i < 16; i++) m[i] = '0;
    end
    for (int b = 0; b < 2; b++) begin
      e.v[b*5+0] = s.rm != 0 ? 32'd0 : rd(s, s.sa, b == 0);
      e.v[b*5+1] = s.rm != 0 ? 32'd0 : rd(s, s.sb, b == 0);
      e.v[b*5+2] = s.rm != 0 ? 32'd0 : rd(s, s.sd, b == 0);
      e.v[b*5+3] = m[15];
      e.v[b*5+4] = m[14];
    end
    q.push_back(e);
    if (s.rm == 1) begin
      #4 rst = 0;
    end
    @(posedge clk);
    #1;
    if (s.rm == 2) rst = 0;
    else begin
      if (s.lrld) m[14] = s.lrin;
      if (s.hz) m[15] = s.pcin;
      if (s.rfld) m[s.c] = s.pw;
    end
  endtask
  task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
    n_cmp++;
    if (a !== e) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", n, a, e);
    end
  endtask
  initial begin
    forever begin
      @(negedge clk);
      #3;
      if (q.size() > 0) begin
        exp_t e;
        logic [9:0][31:0] a;
        e = q.pop_front();
        a = {bn.r14out, bn.pcout, bn.pd, bn.pb, bn.pa, bf.r14out, bf.pcout, bf.pd, bf.pb, bf.pa};
        for (int k = 0; k < 10; k++) chk(names[k], a[k], e.v[k]);
      end
    end
  end
  function automatic stim_t mk(input int rm, input logic [3:0] sa, sb, sd, c, input logic [31:0] pw,
                               input logic rfld, input logic [31:0] lrin, input logic lrld,
                               input logic [31:0] pcin, input logic hz);
    stim_t s;
    s.rm = rm; s.sa = sa; s.sb = sb; s.sd = sd; s.c = c; s.pw = pw; s.rfld = rfld;
    s.lrin = lrin; s.lrld = lrld; s.pcin = pcin; s.hz = hz;
    return s;
  endfunction
  initial begin
    stim_t s;
    for (int i = 0; i < 16; i++) m[i] = '0;
    drive(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    cycle(mk(2, 3, 14, 15, 3, 32'h11, 1, 32'h22, 1, 32'h33, 1));
    cycle(mk(0, 3, 0, 15, 3, 32'h55, 1, 0, 0, 0, 0));
    cycle(mk(0, 3, 3, 3, 0, 0, 0, 0, 0, 0, 0));
    cycle(mk(1, 3, 3, 3, 3, 32'h77, 0, 32'h99, 1, 32'h44, 0));
    cycle(mk(0, 3, 3, 3, 0, 0, 0, 0, 0, 0, 0));
    cycle(mk(0, 3, 3, 3, 3, 32'd90, 1, 0, 0, 0, 0));
    cycle(mk(0, 3, 3, 3, 0, 0, 0, 0, 0, 0, 0));
    cycle(mk(0, 5, 5, 5, 5, 32'hAA, 1, 0, 0, 0, 0));
    cycle(mk(0, 5, 5, 5, 0, 0, 0, 0, 0, 0, 0));
    cycle(mk(0, 15, 15, 15, 0, 0, 0, 0, 0, 0, 1));
    cycle(mk(0, 15, 15, 15, 0, 0, 0, 0, 0, 4, 1));
    cycle(mk(0, 15, 15, 15, 0, 0, 0, 0, 0, 8, 1));
    cycle(mk(0, 15, 15, 15, 0, 0, 0, 0, 0, 12, 0));
    cycle(mk(0, 15, 15, 15, 15, 32'd35, 1, 0, 0, 12, 0));
    cycle(mk(0, 15, 14, 14, 14, 32'd7, 1, 32'd100, 1, 0, 0));
    cycle(mk(0, 14, 14, 15, 0, 0, 0, 32'd100, 1, 0, 0));
    cycle(mk(0, 14, 14, 15, 4'bxxxx, 32'hDEAD, 0, 0, 0, 0, 0));
    cycle(mk(0, 14, 15, 2, 0, 0, 0, 0, 0, 0, 0));
    for (int n = 0; n < 2000; n++) begin
      s.sa = 4'($urandom_range(0, 15));
      s.sb = 4'($urandom_range(0, 15));
      s.sd = $urandom_range(0, 3) == 0 ? s.sa : 4'($urandom_range(0, 15));
      s.c = $urandom_range(0, 3) == 0 ? s.sb : 4'($urandom_range(0, 15));
      s.pw = $urandom;
      s.lrin = $urandom;
      s.pcin = $urandom;
      s.rfld = 1'($urandom_range(0, 1));
      s.lrld = $urandom_range(0, 2) == 0;
      s.hz = 1'($urandom_range(0, 1));
      s.rm = $urandom_range(0, 99) == 0 ? 2 : ($urandom_range(0, 99) == 0 ? 1 : 0);
      cycle(s);
    end
    for (int w = 0; w < 10 && q.size() > 0; w++) @(negedge clk);
    #5;
    n_cmp++;
    if (q.size() != 0) begin
      n_bad++;
      $display("FAIL drain: got %0d pending expected 0", q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
